// File: rtl/mprj_io_seq_monitor.sv
// mprj_io_seq_monitor
// Watches the user-project GPIO pins, debounces them, and walks a
// programmable table of expected byte values. It reports pass, fail
// (mismatch, timeout or bad length), how far the sequence got, and the
// last value that was accepted.

module mprj_io_seq_monitor #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int STABLE = 4,
    parameter int TMO_W  = 16
) (
    input  logic                       clock,
    input  logic                       resetb,
    input  logic [WIDTH-1:0]           pins,
    input  logic                       exp_we,
    input  logic [$clog2(DEPTH)-1:0]   exp_addr,
    input  logic [WIDTH-1:0]           exp_data,
    input  logic [$clog2(DEPTH):0]     seq_len,
    input  logic                       strict,
    input  logic [TMO_W-1:0]           tmo_limit,
    input  logic                       start,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail,
    output logic [1:0]                 fail_code,
    output logic [$clog2(DEPTH):0]     step_idx,
    output logic [WIDTH-1:0]           last_val
);

    localparam int AW    = $clog2(DEPTH);
    localparam int SW    = AW + 1;
    localparam int CNT_W = (STABLE > 1) ? $clog2(STABLE) : 1;

    // The run counter saturates at STABLE-1, which is also the accept point.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE - 1);
    localparam logic [SW-1:0]    DEPTH_S = SW'(DEPTH);

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_BADLEN   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DONE
    } state_t;

    // Pin synchronizer and glitch filter
    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] last_val_q, last_val_d;
    logic             accept;

    // Expected-value table (deliberately not reset)
    logic [WIDTH-1:0] exp_tab_q [DEPTH];
    logic [WIDTH-1:0] exp_cur, exp_prev;

    // Sequencer state
    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic [1:0]       fail_code_q, fail_code_d;
    logic [SW-1:0]    step_idx_q, step_idx_d;
    logic [SW-1:0]    len_q, len_d;
    logic             strict_q, strict_d;
    logic [TMO_W-1:0] tmo_lim_q, tmo_lim_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [SW-1:0]    step_inc;
    logic             hit, miss_fatal, bad_len;

    // Two-flop synchronizer plus one more stage to compare consecutive samples
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            cnt_q      <= '0;
            last_val_q <= '0;
        end else begin
            sync1_q    <= pins;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            cnt_q      <= cnt_d;
            last_val_q <= last_val_d;
        end
    end

    // Count how long the synced value has been steady; accept it once steady and new
    always_comb begin
        cnt_d = '0;
        if (sync2_q == prev_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
        accept     = (cnt_d == CNT_MAX) && (sync2_q != last_val_q);
        last_val_d = accept ? sync2_q : last_val_q;
    end

    // Table writes are allowed at any time; a change is seen by the compare next cycle
    always_ff @(posedge clock) begin
        if (exp_we) begin
            exp_tab_q[exp_addr] <= exp_data;
        end
    end

    assign exp_cur    = exp_tab_q[step_idx_q[AW-1:0]];
    assign exp_prev   = exp_tab_q[AW'(step_idx_q - 1'b1)];
    assign step_inc   = step_idx_q + 1'b1;
    assign hit        = accept && (sync2_q == exp_cur);
    assign miss_fatal = accept && strict_q &&
                        ((step_idx_q == '0) || (sync2_q != exp_prev));
    assign bad_len    = (seq_len == '0) || (seq_len > DEPTH_S);

    // Sequencer state and sticky result registers
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= FC_NONE;
            step_idx_q  <= '0;
            len_q       <= '0;
            strict_q    <= 1'b0;
            tmo_lim_q   <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fail_code_q <= fail_code_d;
            step_idx_q  <= step_idx_d;
            len_q       <= len_d;
            strict_q    <= strict_d;
            tmo_lim_q   <= tmo_lim_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    // Next state: start (re)arms from anywhere; a match outranks the timeout
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        fail_code_d = fail_code_q;
        step_idx_d  = step_idx_q;
        len_d       = len_q;
        strict_d    = strict_q;
        tmo_lim_d   = tmo_lim_q;
        tmo_cnt_d   = tmo_cnt_q;

        if (start) begin
            state_d     = ST_ARMED;
            pass_d      = 1'b0;
            fail_d      = 1'b0;
            fail_code_d = FC_NONE;
            step_idx_d  = '0;
            len_d       = seq_len;
            strict_d    = strict;
            tmo_lim_d   = tmo_limit;
            tmo_cnt_d   = '0;
            if (bad_len) begin
                state_d     = ST_DONE;
                fail_d      = 1'b1;
                fail_code_d = FC_BADLEN;
            end
        end else if (state_q == ST_ARMED) begin
            if (hit) begin
                step_idx_d = step_inc;
                tmo_cnt_d  = '0;
                if (step_inc == len_q) begin
                    pass_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end else if (miss_fatal) begin
                fail_d      = 1'b1;
                fail_code_d = FC_MISMATCH;
                state_d     = ST_DONE;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if ((tmo_lim_q != '0) && (tmo_cnt_d == tmo_lim_q)) begin
                    fail_d      = 1'b1;
                    fail_code_d = FC_TIMEOUT;
                    state_d     = ST_DONE;
                end
            end
        end

        busy_d = (state_d == ST_ARMED);
    end

    assign busy      = busy_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign step_idx  = step_idx_q;
    assign last_val  = last_val_q;

endmodule

// File: tb/tb_mprj_io_seq_monitor.sv
// tb_mprj_io_seq_monitor
// Directed test of the GPIO sequence monitor. A window-based model of the
// debounced pin stream and the sequence rules predicts every output on every
// cycle; hand-computed literals pin down the key scenarios.

module tb_mprj_io_seq_monitor;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int S  = 4;
    localparam int TW = 16;

    localparam logic [7:0] SEQ_A [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                          8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};

    logic          clock = 1'b0;
    logic          resetb;
    logic [W-1:0]  pins;
    logic          exp_we;
    logic [3:0]    exp_addr;
    logic [W-1:0]  exp_data;
    logic [4:0]    seq_len;
    logic          strict;
    logic [TW-1:0] tmo_limit;
    logic          start;
    logic          busy, pass, fail;
    logic [1:0]    fail_code;
    logic [4:0]    step_idx;
    logic [W-1:0]  last_val;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    mprj_io_seq_monitor #(.WIDTH(W), .DEPTH(D), .STABLE(S), .TMO_W(TW)) dut (
        .clock     (clock),
        .resetb    (resetb),
        .pins      (pins),
        .exp_we    (exp_we),
        .exp_addr  (exp_addr),
        .exp_data  (exp_data),
        .seq_len   (seq_len),
        .strict    (strict),
        .tmo_limit (tmo_limit),
        .start     (start),
        .busy      (busy),
        .pass      (pass),
        .fail      (fail),
        .fail_code (fail_code),
        .step_idx  (step_idx),
        .last_val  (last_val)
    );

    always #5 clock = ~clock;

    // Model state
    logic [7:0] m_tab [D];
    logic [7:0] h [S+1];
    bit         m_armed, m_pass, m_fail, m_strict;
    logic [1:0] m_code;
    int         m_step, m_len, m_since, m_lim;
    logic [7:0] m_last;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: h[k] holds the pin sample taken k+1 edges ago; a value is
    // accepted when the S samples two-or-more edges old all agree and differ
    // from the last accepted value.
    always @(posedge clock) begin : model
        bit         acc, same, prev_ok;
        logic [7:0] v;
        if (!resetb) begin
            for (int i = 0; i <= S; i++) h[i] = 8'h00;
            m_armed = 0; m_pass = 0; m_fail = 0; m_strict = 0;
            m_code = 0; m_step = 0; m_len = 0; m_since = 0; m_lim = 0;
            m_last = 8'h00;
        end else begin
            same = 1;
            for (int i = 2; i <= S; i++) if (h[i] != h[1]) same = 0;
            v   = h[1];
            acc = same && (v != m_last);
            if (start) begin
                m_step = 0; m_pass = 0; m_fail = 0; m_code = 0; m_since = 0;
                m_len = int'(seq_len); m_strict = strict; m_lim = int'(tmo_limit);
                if (m_len == 0 || m_len > D) begin
                    m_armed = 0; m_fail = 1; m_code = 3;
                end else begin
                    m_armed = 1;
                end
            end else if (m_armed) begin
                prev_ok = (m_step == 0) ? 1'b1 : (v != m_tab[m_step-1]);
                if (acc && v == m_tab[m_step]) begin
                    m_step++;
                    m_since = 0;
                    if (m_step == m_len) begin m_pass = 1; m_armed = 0; end
                end else if (acc && m_strict && prev_ok) begin
                    m_fail = 1; m_code = 1; m_armed = 0;
                end else begin
                    m_since++;
                    if (m_lim != 0 && m_since == m_lim) begin
                        m_fail = 1; m_code = 2; m_armed = 0;
                    end
                end
            end
            if (acc) m_last = v;
            for (int i = S; i > 0; i--) h[i] = h[i-1];
            h[0] = pins;
        end
        if (exp_we) m_tab[exp_addr] = exp_data;
    end

    // Compare every output against the model once per cycle
    always @(negedge clock) begin
        if (resetb && chk_en) begin
            checkOutput("busy", busy, m_armed);
            checkOutput("pass", pass, m_pass);
            checkOutput("fail", fail, m_fail);
            checkOutput("fail_code", fail_code, m_code);
            checkOutput("step_idx", step_idx, m_step);
            checkOutput("last_val", last_val, m_last);
            checkOutput("pass_and_fail", pass & fail, 0);
        end
    end

    task automatic applyStimulus(input logic [7:0] v, input int hold);
        pins = v;
        repeat (hold) @(negedge clock);
    endtask

    task automatic armSeq(input logic [4:0] len, input logic st, input logic [15:0] lim);
        seq_len   = len;
        strict    = st;
        tmo_limit = lim;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
    endtask

    task automatic loadTable();
        for (int i = 0; i < D; i++) begin
            exp_we   = 1'b1;
            exp_addr = 4'(i);
            exp_data = (i < 12) ? SEQ_A[i] : 8'hEE;
            @(negedge clock);
        end
        exp_we = 1'b0;
    endtask

    task automatic waitStep(input int target, input int budget);
        int n;
        n = 0;
        while (int'(step_idx) != target && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput("wait_step", step_idx, target);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        resetb = 0; pins = 0; exp_we = 0; exp_addr = 0; exp_data = 0;
        seq_len = 0; strict = 0; tmo_limit = 0; start = 0;
        repeat (3) @(negedge clock);
        resetb = 1;
        chk_en = 1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_fail", fail, 0);
        checkOutput("rst_code", fail_code, 0);
        checkOutput("rst_step", step_idx, 0);
        checkOutput("rst_last", last_val, 0);

        loadTable();

        // Full strict sequence
        $display("[TB] full strict sequence");
        armSeq(5'd12, 1'b1, 16'd1000);
        checkOutput("t1_busy", busy, 1);
        for (int i = 0; i < 12; i++) applyStimulus(SEQ_A[i], 10);
        checkOutput("t1_pass", pass, 1);
        checkOutput("t1_fail", fail, 0);
        checkOutput("t1_step", step_idx, 12);
        checkOutput("t1_last", last_val, 8'h00);
        checkOutput("t1_busy_done", busy, 0);

        // Strict mismatch
        $display("[TB] strict mismatch");
        armSeq(5'd12, 1'b1, 16'd1000);
        applyStimulus(8'h01, 10);
        applyStimulus(8'h02, 10);
        applyStimulus(8'h05, 10);
        checkOutput("t2_fail", fail, 1);
        checkOutput("t2_code", fail_code, 1);
        checkOutput("t2_step", step_idx, 2);
        applyStimulus(8'h06, 20);
        checkOutput("t2_hold_code", fail_code, 1);
        checkOutput("t2_hold_step", step_idx, 2);
        checkOutput("t2_hold_last", last_val, 8'h06);

        // Non-strict: a stray value is ignored
        $display("[TB] non-strict sequence with stray value");
        armSeq(5'd12, 1'b0, 16'd1000);
        applyStimulus(8'h01, 10);
        applyStimulus(8'h07, 10);
        for (int i = 1; i < 12; i++) applyStimulus(SEQ_A[i], 10);
        checkOutput("t3_pass", pass, 1);
        checkOutput("t3_fail", fail, 0);
        checkOutput("t3_step", step_idx, 12);

        // Glitch shorter than the filter window
        $display("[TB] glitch rejection");
        armSeq(5'd12, 1'b1, 16'd1000);
        applyStimulus(8'h01, 10);
        applyStimulus(8'h03, S - 1);
        applyStimulus(8'h01, 10);
        applyStimulus(8'h02, 10);
        checkOutput("t4_step", step_idx, 2);
        checkOutput("t4_fail", fail, 0);
        checkOutput("t4_busy", busy, 1);
        checkOutput("t4_last", last_val, 8'h02);

        // Timeout 50 cycles after the last match
        $display("[TB] timeout");
        armSeq(5'd12, 1'b1, 16'd50);
        pins = 8'h01;
        waitStep(1, 30);
        n = 0;
        while (!fail && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("t5_tmo_cycles", n, 50);
        checkOutput("t5_code", fail_code, 2);
        checkOutput("t5_step", step_idx, 1);

        // Match landing exactly in the limit cycle
        $display("[TB] match in limit cycle");
        applyStimulus(8'h00, 10);
        armSeq(5'd12, 1'b1, 16'd50);
        pins = 8'h01;
        waitStep(1, 30);
        repeat (44) @(negedge clock);
        pins = 8'h02;
        repeat (5) @(negedge clock);
        checkOutput("t5b_step_before", step_idx, 1);
        checkOutput("t5b_fail_before", fail, 0);
        @(negedge clock);
        checkOutput("t5b_step", step_idx, 2);
        checkOutput("t5b_fail", fail, 0);
        checkOutput("t5b_busy", busy, 1);

        // Asynchronous reset mid-sequence
        $display("[TB] reset mid-sequence");
        armSeq(5'd12, 1'b1, 16'd1000);
        for (int i = 0; i < 5; i++) applyStimulus(SEQ_A[i], 10);
        checkOutput("t6_step", step_idx, 5);
        #1 resetb = 0;
        #1;
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_pass", pass, 0);
        checkOutput("t6_fail", fail, 0);
        checkOutput("t6_code", fail_code, 0);
        checkOutput("t6_step0", step_idx, 0);
        checkOutput("t6_last", last_val, 0);
        repeat (2) @(negedge clock);
        resetb = 1;
        repeat (10) @(negedge clock);
        checkOutput("t6_last_after", last_val, 8'h05);

        // Length checks
        $display("[TB] length boundaries");
        armSeq(5'd0, 1'b1, 16'd1000);
        checkOutput("t7_len0_fail", fail, 1);
        checkOutput("t7_len0_code", fail_code, 3);
        checkOutput("t7_len0_busy", busy, 0);
        armSeq(5'd17, 1'b1, 16'd1000);
        checkOutput("t7_len17_code", fail_code, 3);
        armSeq(5'd16, 1'b0, 16'd0);
        checkOutput("t7_len16_busy", busy, 1);
        checkOutput("t7_len16_fail", fail, 0);
        repeat (5) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mprj_io_seq_monitor.md
Name: mprj_io_seq_monitor

Overview:
- Synthesizable checker that sits directly downstream of the user-project GPIO pads (mprj_io[7:0]).
- Samples the pins, filters glitches, and steps through a programmed sequence of expected byte values, e.g. 01..0A, FF, 00.
- Flags pass, fail or timeout, replacing ad-hoc wait chains in DV benches. It is reusable in FPGA bring-up.

Parameters:
- WIDTH, 8, observed pin-bus width.
- DEPTH, 16, maximum expected-sequence length (entries).
- STABLE, 4, consecutive identical samples required before a value is accepted (>=1).
- TMO_W, 16, timeout counter width.

Ports:
- clock  in  1  sampling clock.
- resetb  in  1  asynchronous active-low reset.
- pins  in  WIDTH  raw mprj_io bits, asynchronous to clock.
- exp_we  in  1  write strobe for the expected-value table.
- exp_addr  in  $clog2(DEPTH)  table index.
- exp_data  in  WIDTH  expected value.
- seq_len  in  $clog2(DEPTH)+1  number of valid entries (1..DEPTH). Sampled at start.
- strict  in  1  1 = any accepted value other than current/previous expected is a failure. Sampled at start.
- tmo_limit  in  TMO_W  cycles allowed between matches; 0 disables the timeout. Sampled at start.
- start  in  1  single-cycle arm pulse.
- busy  out  1  high while in ARMED.
- pass  out  1  sticky pass.
- fail  out  1  sticky fail.
- fail_code  out  2  reason: 0 none, 1 mismatch, 2 timeout, 3 bad length.
- step_idx  out  $clog2(DEPTH)+1  number of entries matched so far.
- last_val  out  WIDTH  most recently accepted stable value.

Behaviour:
- Reset (resetb low, async): all outputs 0, FSM IDLE, synchronizer and filter cleared. The table contents are not reset.
- Synchronizer: 2-flop synchronizer on pins.
  - Filter counter counts consecutive cycles where the synced value equals the previous synced value.
  - When the count reaches STABLE-1 and the value differs from last_val, an "accept" event fires for one cycle with that value. last_val updates in that same cycle.
  - Latency from a pin change to accept = 2 + STABLE cycles.
  - The filter runs in all states.
- Table: DEPTH x WIDTH registers.
  - Writes are honoured in any state. A write to the entry currently being compared while ARMED takes effect the next cycle.
- FSM states: IDLE, ARMED, DONE.
  - IDLE: start -> ARMED. On the same edge:
    - step_idx = 0, pass = fail = 0, fail_code = 0;
    - seq_len, strict and tmo_limit are latched;
    - the timeout counter is cleared.
  - IDLE, bad length: if seq_len is 0 or >DEPTH at start, go directly to DONE with fail = 1, fail_code = 3.
  - ARMED, accept with value == table[step_idx]: step_idx++ and the timeout counter clears.
    - If the new step_idx == latched length: pass = 1, go to DONE.
  - ARMED, accept with value mismatching, strict = 1, and (step_idx == 0 or value != table[step_idx-1]): fail = 1, fail_code = 1, go to DONE.
  - ARMED, mismatching accept with strict = 0: ignored.
  - ARMED, timeout: the counter increments every cycle without a match. When it equals tmo_limit (limit != 0): fail = 1, fail_code = 2, go to DONE.
  - ARMED, same-cycle priority: match beats timeout, so a match in the limit cycle passes/advances.
  - DONE: holds pass/fail/fail_code/step_idx. start re-arms exactly as from IDLE.
  - start while ARMED: restarts (same as the IDLE transition). step_idx returns to 0.
- busy = (state == ARMED), registered.
- A value already stable on the pins when armed is not re-accepted; accept only fires on a change relative to last_val.
  - A sequence whose first entry equals the current last_val therefore requires the pins to leave and return.
- pass and fail are never both 1.

Test Plan:
- Load 01..0A,FF,00 (seq_len 12, strict 1, tmo 1000); drive the sequence, each value held 10 cycles -> pass = 1, step_idx = 12, last_val = 00, fail = 0.
- Same load; drive 01,02,05 -> fail = 1, fail_code = 1, step_idx = 2, DONE holds until the next start.
- Same load, strict 0; drive 01,07,02..0A,FF,00 -> 07 is ignored, pass = 1.
- Glitch: drive 01, then 03 for STABLE-1 cycles, then 01 again, then 02 -> no accept of 03, step_idx = 2 after 02.
- Timeout: tmo_limit 50; after 01 hold pins static -> fail_code = 2 exactly 50 cycles after the match. Separately, a match landing in the limit cycle -> advances, no fail.
- Reset mid-sequence: assert resetb low at step_idx = 5 -> all outputs 0 immediately (async). seq_len = 0 at start -> fail_code = 3 next cycle.
